// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button conditioner:
//   - default timing constants for a 25 MHz clock
//   - repeat FSM state encoding
//   - board button index constants
//   - max_int helper used for counter sizing
// Optional build macro used by the design: BUTTON_CONDITIONER_SYNC_EN
// ---------------------------------------------------------------------------
package button_pkg;

    localparam int DEBOUNCE_CYCLES      = 1000000;   // 40 ms
    localparam int REPEAT_DELAY_CYCLES  = 12500000;  // 0.5 s
    localparam int REPEAT_PERIOD_CYCLES = 2500000;   // 0.1 s

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    localparam int BTN_CHOP  = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One conditioned pushbutton: optional 2-flop synchronizer, stability-count
// debounce, registered rise/fall pulses and a press pulse with auto-repeat.
//
// Build macro: BUTTON_CONDITIONER_SYNC_EN
//   defined   -> two reset-to-0 synchronizer flops ahead of the debouncer
//   undefined -> noisy_in feeds the debouncer directly
//
// Ports:
//   clock_in   system clock
//   reset_in   synchronous active-high reset
//   noisy_in   raw button level
//   clean_out  debounced level
//   rise_out   one-cycle pulse in the first cycle clean_out is 1
//   fall_out   one-cycle pulse in the first cycle clean_out is 0
//   press_out  pulse on rise, then auto-repeat pulses while held
// ---------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int STABLE_COUNT  = DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_CYCLES,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic noisy_in,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out,
    output logic press_out
);

    localparam int CNT_W    = $clog2(STABLE_COUNT + 1);
    localparam int RCNT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RCNT_W   = (RCNT_MAX > 1) ? $clog2(RCNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_COUNT);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic deb_in;

`ifdef BUTTON_CONDITIONER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], noisy_in};
        end
    end

    assign deb_in = sync_q[1];
`else
    assign deb_in = noisy_in;
`endif

    // ---------------- debounce ----------------
    logic             samp_q,  samp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clean_q, clean_d;
    logic             rise_q,  fall_q;
    logic             rise_d,  fall_d;

    // Count saturates at STABLE_COUNT so clean keeps tracking samp while the
    // input stays put; any difference restarts the window.
    always_comb begin
        samp_d  = samp_q;
        count_d = count_q;
        clean_d = clean_q;
        if (deb_in != samp_q) begin
            samp_d  = deb_in;
            count_d = '0;
        end else if (count_q == STABLE_LAST) begin
            clean_d = samp_q;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign rise_d = clean_d & ~clean_q;
    assign fall_d = ~clean_d & clean_q;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            samp_q  <= 1'b0;
            count_q <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            samp_q  <= samp_d;
            count_q <= count_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // ---------------- repeat FSM ----------------
    rep_state_t        state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q,  rcnt_d;
    logic              press_q, press_d;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= REP_IDLE;
            rcnt_q  <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            press_q <= press_d;
        end
    end

    // A release always wins over a repeat expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        if (fall_d) begin
            state_d = REP_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                REP_IDLE: begin
                    if (rise_d && REPEAT_EN) begin
                        state_d = REP_DELAY;
                        rcnt_d  = '0;
                    end
                end
                REP_DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        state_d = REP_REPEAT;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
                REP_REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_W'(1);
                    end
                end
                default: begin
                    state_d = REP_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        press_d = 1'b0;
        if (!fall_d) begin
            case (state_q)
                REP_IDLE:   press_d = rise_d;
                REP_DELAY:  press_d = (rcnt_q == DELAY_LAST);
                REP_REPEAT: press_d = (rcnt_q == PERIOD_LAST);
                default:    press_d = 1'b0;
            endcase
        end
    end

    assign clean_out = clean_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;
    assign press_out = press_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions N raw pushbuttons: debounced level, rise/fall pulses and a press
// pulse with per-channel maskable auto-repeat. Channels are independent.
//
// Build macro: BUTTON_CONDITIONER_SYNC_EN (adds a 2-flop synchronizer per
// channel ahead of the debouncer; latencies grow by 2 cycles).
//
// Ports:
//   clock_in          system clock
//   reset_in          synchronous active-high reset
//   noisy_in  [N-1:0] raw button levels (asynchronous)
//   clean_out [N-1:0] debounced levels
//   rise_out  [N-1:0] one-cycle pulse when clean goes high
//   fall_out  [N-1:0] one-cycle pulse when clean goes low
//   press_out [N-1:0] press pulse plus auto-repeat pulses
// ---------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int             N             = 5,
    parameter int             STABLE_COUNT  = DEBOUNCE_CYCLES,
    parameter int             REPEAT_DELAY  = REPEAT_DELAY_CYCLES,
    parameter int             REPEAT_PERIOD = REPEAT_PERIOD_CYCLES,
    parameter logic [N-1:0]   REPEAT_MASK   = {N{1'b1}}
) (
    input  logic         clock_in,
    input  logic         reset_in,
    input  logic [N-1:0] noisy_in,
    output logic [N-1:0] clean_out,
    output logic [N-1:0] rise_out,
    output logic [N-1:0] fall_out,
    output logic [N-1:0] press_out
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            button_channel #(
                .STABLE_COUNT  (STABLE_COUNT),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD),
                .REPEAT_EN     (REPEAT_MASK[gi])
            ) u_chan (
                .clock_in  (clock_in),
                .reset_in  (reset_in),
                .noisy_in  (noisy_in[gi]),
                .clean_out (clean_out[gi]),
                .rise_out  (rise_out[gi]),
                .fall_out  (fall_out[gi]),
                .press_out (press_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Two instances share the same stimulus: dut_a with repeat on every channel,
// dut_b with channel 2 repeat masked off. A window-based reference model
// predicts every output each cycle; a vector table and hand sequences add
// explicit expectations for the key timing corners.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BUTTON_CONDITIONER_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam logic [3:0] MASK_A = 4'b1111;
    localparam logic [3:0] MASK_B = 4'b1011;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] noisy;
    logic [3:0] clean_a, rise_a, fall_a, press_a;
    logic [3:0] clean_b, rise_b, fall_b, press_b;

    always #5 clk = ~clk;

    button_conditioner #(
        .N(N), .STABLE_COUNT(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_MASK(MASK_A)
    ) dut_a (
        .clock_in(clk), .reset_in(rst), .noisy_in(noisy),
        .clean_out(clean_a), .rise_out(rise_a), .fall_out(fall_a), .press_out(press_a)
    );

    button_conditioner #(
        .N(N), .STABLE_COUNT(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .REPEAT_MASK(MASK_B)
    ) dut_b (
        .clock_in(clk), .reset_in(rst), .noisy_in(noisy),
        .clean_out(clean_b), .rise_out(rise_b), .fall_out(fall_b), .press_out(press_b)
    );

    int checks = 0;
    int errors = 0;
    int t = 0;

    // ---------------- reference model ----------------
    logic [3:0] m_s1, m_s2, m_clean, m_rise, m_fall, m_pa, m_pb;
    logic [3:0] run_val;
    int         run_len [4];
    int         rise_t  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    // Clean takes value v once the last SC+2 samples (SC+1 stable cycles after
    // the change) all equal v; a reset edge acts as a sample of 0.
    task automatic model_update(input logic r, input logic [3:0] nz);
        logic [3:0] v;
        logic [3:0] nc;
        int         d;
        bit         rep;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
            m_pa = '0; m_pb = '0; run_val = '0;
            for (int i = 0; i < 4; i++) begin
                run_len[i] = 1;
                rise_t[i]  = 0;
            end
        end else begin
`ifdef BUTTON_CONDITIONER_SYNC_EN
            v = m_s2; m_s2 = m_s1; m_s1 = nz;
`else
            v = nz;
`endif
            nc = m_clean;
            for (int i = 0; i < 4; i++) begin
                if (v[i] == run_val[i]) begin
                    if (run_len[i] < SC + 2) run_len[i]++;
                end else begin
                    run_val[i] = v[i];
                    run_len[i] = 1;
                end
                if (run_len[i] >= SC + 2) nc[i] = run_val[i];
            end
            m_rise = nc & ~m_clean;
            m_fall = ~nc & m_clean;
            for (int i = 0; i < 4; i++) begin
                m_pa[i] = 1'b0;
                m_pb[i] = 1'b0;
                if (m_rise[i]) begin
                    rise_t[i] = t;
                    m_pa[i] = 1'b1;
                    m_pb[i] = 1'b1;
                end else if (nc[i]) begin
                    d   = t - rise_t[i];
                    rep = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
                    m_pa[i] = rep & MASK_A[i];
                    m_pb[i] = rep & MASK_B[i];
                end
            end
            m_clean = nc;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] nz);
        @(negedge clk);
        rst   = r;
        noisy = nz;
        @(posedge clk);
        #1;
        t++;
        model_update(r, nz);
        chk("model_clean_a", 32'(clean_a), 32'(m_clean));
        chk("model_rise_a",  32'(rise_a),  32'(m_rise));
        chk("model_fall_a",  32'(fall_a),  32'(m_fall));
        chk("model_press_a", 32'(press_a), 32'(m_pa));
        chk("model_clean_b", 32'(clean_b), 32'(m_clean));
        chk("model_rise_b",  32'(rise_b),  32'(m_rise));
        chk("model_fall_b",  32'(fall_b),  32'(m_fall));
        chk("model_press_b", 32'(press_b), 32'(m_pb));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] noisy;
        logic [3:0] exp_clean;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
        logic [3:0] exp_press;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int start, n_a, cnt_b, rel, fall_t, extra, dedge, rise_at, r_base;
        int times_a [4];
        logic [3:0] nz;

        rst   = 1'b1;
        noisy = '0;

        // Two reset rows with every button held, then edges 0..13:
        // ch0 steps to 1 at edge 0; ch1 goes 1,1,0,1 then holds 1.
        for (int i = 0; i < 16; i++) begin
            int e;
            logic ch1;
            e   = i - 2;
            ch1 = (e == 2) ? 1'b0 : 1'b1;
            vecs[i].rst       = (i < 2);
            vecs[i].noisy     = (i < 2) ? 4'b1111 : {2'b00, ch1, 1'b1};
            vecs[i].exp_clean = {2'b00, 1'(e >= 8 + SL), 1'(e >= 5 + SL)};
            vecs[i].exp_rise  = {2'b00, 1'(e == 8 + SL), 1'(e == 5 + SL)};
            vecs[i].exp_fall  = 4'b0000;
            vecs[i].exp_press = {2'b00, 1'(e == 8 + SL), 1'(e == 5 + SL)};
        end

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].noisy);
            chk($sformatf("tbl%0d_clean", i), 32'(clean_a), 32'(vecs[i].exp_clean));
            chk($sformatf("tbl%0d_rise",  i), 32'(rise_a),  32'(vecs[i].exp_rise));
            chk($sformatf("tbl%0d_fall",  i), 32'(fall_a),  32'(vecs[i].exp_fall));
            chk($sformatf("tbl%0d_press", i), 32'(press_a), 32'(vecs[i].exp_press));
        end

        // ---- ch2 held: repeat spacing, masked instance, release ----
        step(1'b1, 4'b0000);
        start = t + 1;
        n_a   = 0;
        cnt_b = 0;
        for (int i = 0; i < 4; i++) times_a[i] = -1000;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 4'b0100);
            if (press_a[2]) begin
                if (n_a < 4) times_a[n_a] = t;
                n_a++;
            end
            if (press_b[2]) cnt_b++;
        end
        chk("hold_first_press",  32'(times_a[0] - start),      32'(SC + 1 + SL));
        chk("hold_second_press", 32'(times_a[1] - times_a[0]), 32'(RD));
        chk("hold_third_press",  32'(times_a[2] - times_a[0]), 32'(RD + RP));
        chk("hold_fourth_press", 32'(times_a[3] - times_a[0]), 32'(RD + 2 * RP));
        chk("masked_press_count", 32'(cnt_b), 32'(1));
        rel    = t + 1;
        fall_t = -1;
        extra  = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 4'b0000);
            if (fall_a[2] && fall_t < 0) fall_t = t;
            if (fall_t >= 0 && press_a[2]) extra++;
        end
        chk("release_fall_latency", 32'(fall_t - rel), 32'(SC + 1 + SL));
        chk("press_after_fall",     32'(extra),        32'(0));

        // ---- ch3: clean falls exactly when the third repeat would fire ----
        step(1'b1, 4'b0000);
        start  = t + 1;
        r_base = start + SC + 1 + SL;
        for (int k = 0; k < 28; k++) begin
            step(1'b0, (k < 16) ? 4'b1000 : 4'b0000);
            if (t == r_base + RD + 2 * RP) begin
                chk("coincide_fall",  32'(fall_a[3]),  32'(1));
                chk("coincide_press", 32'(press_a[3]), 32'(0));
            end
        end

        // ---- reset while ch0 is repeating, button still held ----
        step(1'b1, 4'b0000);
        for (int k = 0; k < 25; k++) step(1'b0, 4'b0001);
        step(1'b1, 4'b0001);
        chk("rst_clean", 32'(clean_a), 32'(0));
        chk("rst_rise",  32'(rise_a),  32'(0));
        chk("rst_fall",  32'(fall_a),  32'(0));
        chk("rst_press", 32'(press_a), 32'(0));
        dedge   = t + 1;
        rise_at = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b0001);
            if (rise_a[0] && rise_at < 0) rise_at = t;
        end
        chk("rise_after_reset", 32'(rise_at - dedge), 32'(SC + 1 + SL));

        // ---- randomized activity against the model ----
        nz = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 19) == 0) nz[i] = ~nz[i];
            end
            step(($urandom_range(0, 149) == 0), nz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
